// File: rtl/fec_pkg.sv
// Shared FEC codec definitions: default frame geometry, symbol type and gather FSM states.
package fec_pkg;
  localparam int FEC_M     = 3;
  localparam int FEC_WIDTH = 11;

  typedef logic [FEC_WIDTH-2:0] fec_data_t;

  typedef enum logic {
    FILL    = 1'b0,
    DISCARD = 1'b1
  } gather_state_e;
endpackage

// File: rtl/fec_gather_bank.sv
// One M-slot symbol bank: write-at-index with optional zero fill of the slots above it,
// plus a full flag. Everything clears asynchronously on reset.
module fec_gather_bank
  import fec_pkg::*;
#(
  parameter int M      = FEC_M,
  parameter int DATA_W = FEC_WIDTH - 1,
  localparam int IDX_W = $clog2(M)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       zero_fill,
  input  logic                       set_full,
  input  logic                       clr_full,
  output logic                       full,
  output logic [M-1:0][DATA_W-1:0]   data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      if (wr_en) begin
        for (int i = 0; i < M; i++) begin
          if (i == int'(wr_idx))
            data[i] <= wr_data;
          else if (zero_fill && (i > int'(wr_idx)))
            data[i] <= '0;
        end
      end
      // A bank is only written while empty and only popped while full, so these never collide.
      if (set_full)
        full <= 1'b1;
      else if (clr_full)
        full <= 1'b0;
    end
  end

endmodule

// File: rtl/fec_frame_gather.sv
// Serial-to-frame gatherer: collects M symbols per frame into ping-pong banks, pads short
// frames with zeros, truncates long ones, and presents frames to the codec.
module fec_frame_gather
  import fec_pkg::*;
#(
  parameter int M       = FEC_M,
  parameter int WIDTH   = FEC_WIDTH,
  localparam int DATA_W = WIDTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_symbol,
  input  logic                       in_last,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [M-1:0][DATA_W-1:0]   frame_symbols,
  output logic                       err_short,
  output logic                       err_long,
  output logic [15:0]                frame_count
);

  localparam int IDX_W = $clog2(M);

  gather_state_e              state_q, state_d;
  logic                       wr_bank, rd_bank;
  logic [IDX_W-1:0]           idx;
  logic [1:0]                 full;
  logic [M-1:0][DATA_W-1:0]   bank_data [2];
  logic                       fill_acc, close_frame, last_slot, pop;

  assign last_slot = (idx == IDX_W'(M - 1));
  assign pop       = frame_valid && frame_ready;

  // in_ready depends only on registered state, so frame_ready never reaches it combinationally.
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    fill_acc    = 1'b0;
    close_frame = 1'b0;
    if (!rst) begin
      case (state_q)
        FILL: begin
          in_ready    = !full[wr_bank];
          fill_acc    = in_valid && !full[wr_bank];
          close_frame = fill_acc && (in_last || last_slot);
          if (fill_acc && last_slot && !in_last)
            state_d = DISCARD;
        end
        DISCARD: begin
          in_ready = 1'b1;
          if (in_valid && in_last)
            state_d = FILL;
        end
        default: state_d = FILL;
      endcase
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fec_gather_bank #(
      .M      (M),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (fill_acc && (wr_bank == 1'(b))),
      .wr_idx    (idx),
      .wr_data   (in_symbol),
      .zero_fill (in_last),
      .set_full  (close_frame && (wr_bank == 1'(b))),
      .clr_full  (pop && (rd_bank == 1'(b))),
      .full      (full[b]),
      .data      (bank_data[b])
    );
  end

  assign frame_valid   = full[rd_bank];
  assign frame_symbols = bank_data[rd_bank];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      idx         <= '0;
      frame_count <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (close_frame) begin
        wr_bank <= !wr_bank;
        idx     <= '0;
      end else if (fill_acc) begin
        idx <= idx + IDX_W'(1);
      end
      if (pop) begin
        rd_bank     <= !rd_bank;
        frame_count <= frame_count + 16'd1;
      end
      err_short <= close_frame && in_last && !last_slot;
      err_long  <= close_frame && !in_last;
    end
  end

endmodule

// File: tb/tb_fec_frame_gather.sv
// Bench for fec_frame_gather: directed scenarios then random traffic, checked every cycle
// against a frame-queue model of the gatherer.
module tb_fec_frame_gather;
  import fec_pkg::*;

  localparam int M  = 3;
  localparam int DW = FEC_WIDTH - 1;

  typedef logic [M-1:0][DW-1:0] frame_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_symbol;
  logic           in_last;
  logic           frame_valid;
  logic           frame_ready;
  frame_t         frame_symbols;
  logic           err_short;
  logic           err_long;
  logic [15:0]    frame_count;

  fec_frame_gather #(.M(M), .WIDTH(FEC_WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_symbol     (in_symbol),
    .in_last       (in_last),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .frame_symbols (frame_symbols),
    .err_short     (err_short),
    .err_long      (err_long),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: completed frames waiting for the consumer, the frame being collected,
  // and whether input is being thrown away after an over-long frame.
  frame_t      pend[$];
  fec_data_t   part[$];
  logic        discard;
  logic [15:0] exp_cnt;
  logic        exp_es, exp_el;

  function automatic logic m_ready();
    return !rst && (discard || (pend.size() < 2));
  endfunction

  function automatic frame_t mk(input int a, input int b, input int c);
    frame_t f;
    f[0] = DW'(a);
    f[1] = DW'(b);
    f[2] = DW'(c);
    return f;
  endfunction

  task automatic model_reset();
    pend.delete();
    part.delete();
    discard = 1'b0;
    exp_cnt = '0;
    exp_es  = 1'b0;
    exp_el  = 1'b0;
  endtask

  task automatic model_edge(input logic acc, input logic pop, input fec_data_t s, input logic l);
    frame_t f;
    exp_es = 1'b0;
    exp_el = 1'b0;
    if (pop) begin
      void'(pend.pop_front());
      exp_cnt = exp_cnt + 16'd1;
    end
    if (acc) begin
      if (discard) begin
        if (l) discard = 1'b0;
      end else begin
        part.push_back(s);
        if (l || (part.size() == M)) begin
          f = '0;
          for (int i = 0; i < part.size(); i++) f[i] = part[i];
          pend.push_back(f);
          exp_es  = l && (part.size() < M);
          exp_el  = !l;
          discard = !l;
          part.delete();
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", 64'(in_ready), 64'(m_ready()));
    chk("frame_valid", 64'(frame_valid), 64'(pend.size() > 0));
    if (pend.size() > 0) chk("frame_symbols", 64'(frame_symbols), 64'(pend[0]));
    chk("err_short", 64'(err_short), 64'(exp_es));
    chk("err_long", 64'(err_long), 64'(exp_el));
    chk("frame_count", 64'(frame_count), 64'(exp_cnt));
  endtask

  // One clock: drive, check at the falling edge, then advance the model at the rising edge.
  task automatic cycle(input logic v, input fec_data_t s, input logic l, input logic fr,
                       output logic acc);
    logic pop;
    in_valid    = v;
    in_symbol   = s;
    in_last     = l;
    frame_ready = fr;
    @(negedge clk);
    check_outputs();
    acc = v && m_ready();
    pop = (pend.size() > 0) && fr;
    @(posedge clk);
    model_edge(acc, pop, s, l);
    #1;
  endtask

  task automatic send(input int s, input logic l, input logic fr);
    logic a;
    int tries;
    tries = 0;
    do begin
      cycle(1'b1, fec_data_t'(s), l, fr, a);
      tries++;
    end while (!a && tries < 40);
    chk("send_accepted", 64'(a), 64'(1));
  endtask

  task automatic idle(input int n, input logic fr);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, fr, a);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    chk({tag, "_frame_valid"}, 64'(frame_valid), 64'(0));
    chk({tag, "_err_short"}, 64'(err_short), 64'(0));
    chk({tag, "_err_long"}, 64'(err_long), 64'(0));
    chk({tag, "_frame_count"}, 64'(frame_count), 64'(0));
    chk({tag, "_frame_symbols"}, 64'(frame_symbols), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    rst = 1'b1;
    in_valid = 1'b0;
    in_symbol = '0;
    in_last = 1'b0;
    frame_ready = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Nominal frame with the consumer always ready
    send(753, 1'b0, 1'b1);
    send(1000, 1'b0, 1'b1);
    send(748, 1'b1, 1'b1);
    chk("nom_valid", 64'(frame_valid), 64'(1));
    chk("nom_frame", 64'(frame_symbols), 64'(mk(753, 1000, 748)));
    idle(1, 1'b1);
    chk("nom_count", 64'(frame_count), 64'(1));
    chk("nom_no_err", 64'({err_short, err_long}), 64'(0));

    // Short frame is zero padded
    send(5, 1'b1, 1'b1);
    chk("short_frame", 64'(frame_symbols), 64'(mk(5, 0, 0)));
    chk("short_pulse", 64'(err_short), 64'(1));
    idle(2, 1'b1);

    // Long frame: truncated, extra symbols dropped, next frame intact
    send(1, 1'b0, 1'b1);
    send(2, 1'b0, 1'b1);
    send(3, 1'b0, 1'b1);
    chk("long_frame", 64'(frame_symbols), 64'(mk(1, 2, 3)));
    chk("long_pulse", 64'(err_long), 64'(1));
    send(4, 1'b0, 1'b1);
    send(9, 1'b1, 1'b1);
    send(7, 1'b0, 1'b1);
    send(8, 1'b0, 1'b1);
    send(6, 1'b1, 1'b1);
    chk("after_long_frame", 64'(frame_symbols), 64'(mk(7, 8, 6)));
    idle(2, 1'b1);

    // Backpressure: two frames fill both banks
    send(11, 1'b0, 1'b0);
    send(12, 1'b0, 1'b0);
    send(13, 1'b1, 1'b0);
    send(21, 1'b0, 1'b0);
    send(22, 1'b0, 1'b0);
    send(23, 1'b1, 1'b0);
    chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    chk("bp_frame_a", 64'(frame_symbols), 64'(mk(11, 12, 13)));
    idle(2, 1'b0);
    idle(1, 1'b1);
    chk("bp_in_ready_back", 64'(in_ready), 64'(1));
    chk("bp_frame_b", 64'(frame_symbols), 64'(mk(21, 22, 23)));
    idle(2, 1'b1);

    // Overlap: fill the free bank while the full one is popped
    send(31, 1'b0, 1'b0);
    send(32, 1'b0, 1'b0);
    send(33, 1'b1, 1'b0);
    send(41, 1'b0, 1'b1);
    send(42, 1'b0, 1'b0);
    send(43, 1'b1, 1'b0);
    chk("ovl_frame", 64'(frame_symbols), 64'(mk(41, 42, 43)));
    idle(2, 1'b1);

    // Reset in the middle of a frame, with another frame pending
    send(51, 1'b1, 1'b0);
    send(61, 1'b0, 1'b0);
    send(62, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(71, 1'b0, 1'b1);
    send(72, 1'b0, 1'b1);
    send(73, 1'b1, 1'b1);
    chk("rst_frame", 64'(frame_symbols), 64'(mk(71, 72, 73)));
    idle(1, 1'b1);
    chk("rst_count", 64'(frame_count), 64'(1));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, fec_data_t'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0, a);
    end
    idle(4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
